// File: rtl/hub_defs_pkg.sv
// Shared hub-bus definitions: request size codes, sys op codes and the
// request-side state encoding used by the per-cog hub requester.
package hub_defs;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_WORD = 2'b01,
      SZ_LONG = 2'b10,
      SZ_SYS  = 2'b11
   } hub_size_e;

   // Selected by the low three address bits when the size code is SZ_SYS
   typedef enum logic [2:0] {
      SYS_CLKSET  = 3'd0,
      SYS_COGID   = 3'd1,
      SYS_COGINIT = 3'd2,
      SYS_COGSTOP = 3'd3,
      SYS_LOCKNEW = 3'd4,
      SYS_LOCKRET = 3'd5,
      SYS_LOCKSET = 3'd6,
      SYS_LOCKCLR = 3'd7
   } hub_sys_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAPT = 2'd2
   } hub_state_e;

endpackage

// File: rtl/cog_hub_req.sv
// Per-cog hub bus initiator: issues one op, holds it until the slot ack,
// then captures the hub's return data one hub stage later with a wait count.
module cog_hub_req
   import hub_defs::*;
#(
   parameter int LAT_W = 4
) (
   input  logic             clk_cog,
   input  logic             nres,
   input  logic             ena_bus,
   input  logic             cog_ena,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_r,
   input  logic             req_w,
   input  logic [1:0]       req_s,
   input  logic [15:0]      req_a,
   input  logic [31:0]      req_d,
   output logic             rsp_valid,
   output logic [31:0]      rsp_q,
   output logic             rsp_c,
   output logic [LAT_W-1:0] rsp_lat,
   output logic             bus_r,
   output logic             bus_e,
   output logic             bus_w,
   output logic [1:0]       bus_s,
   output logic [15:0]      bus_a,
   output logic [31:0]      bus_d,
   input  logic [31:0]      bus_q,
   input  logic             bus_c,
   input  logic             bus_ack
);

   hub_state_e       state_q, state_d;
   logic             bus_r_q, bus_r_d;
   logic             bus_e_q, bus_e_d;
   logic             bus_w_q, bus_w_d;
   logic [1:0]       bus_s_q, bus_s_d;
   logic [15:0]      bus_a_q, bus_a_d;
   logic [31:0]      bus_d_q, bus_d_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_q_q, rsp_q_d;
   logic             rsp_c_q, rsp_c_d;
   logic [LAT_W-1:0] rsp_lat_q, rsp_lat_d;

   function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
      return (&v) ? v : v + LAT_W'(1);
   endfunction

   always_comb begin
      state_d     = state_q;
      bus_r_d     = bus_r_q;
      bus_e_d     = bus_e_q;
      bus_w_d     = bus_w_q;
      bus_s_d     = bus_s_q;
      bus_a_d     = bus_a_q;
      bus_d_d     = bus_d_q;
      lat_d       = lat_q;
      rsp_q_d     = rsp_q_q;
      rsp_c_d     = rsp_c_q;
      rsp_lat_d   = rsp_lat_q;
      rsp_valid_d = 1'b0;

      if (ena_bus) begin
         // A stopped cog abandons whatever the hub still has in flight
         if (!cog_ena) begin
            state_d = ST_IDLE;
            bus_e_d = 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (req_valid) begin
                     bus_r_d = req_r;
                     bus_w_d = req_w;
                     bus_s_d = req_s;
                     bus_a_d = req_a;
                     bus_d_d = req_d;
                     bus_e_d = 1'b1;
                     lat_d   = '0;
                     state_d = ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  lat_d = sat_inc(lat_q);
                  if (bus_ack) begin
                     bus_e_d = 1'b0;
                     state_d = ST_CAPT;
                  end
               end
               ST_CAPT: begin
                  // Return data trails the ack by one hub stage
                  rsp_q_d     = bus_q;
                  rsp_c_d     = bus_c;
                  rsp_lat_d   = lat_q;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_cog or negedge nres) begin
      if (!nres) begin
         state_q     <= ST_IDLE;
         bus_r_q     <= 1'b0;
         bus_e_q     <= 1'b0;
         bus_w_q     <= 1'b0;
         bus_s_q     <= 2'b00;
         bus_a_q     <= 16'h0000;
         bus_d_q     <= 32'h0000_0000;
         lat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_q_q     <= 32'h0000_0000;
         rsp_c_q     <= 1'b0;
         rsp_lat_q   <= '0;
      end else begin
         state_q     <= state_d;
         bus_r_q     <= bus_r_d;
         bus_e_q     <= bus_e_d;
         bus_w_q     <= bus_w_d;
         bus_s_q     <= bus_s_d;
         bus_a_q     <= bus_a_d;
         bus_d_q     <= bus_d_d;
         lat_q       <= lat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q_q     <= rsp_q_d;
         rsp_c_q     <= rsp_c_d;
         rsp_lat_q   <= rsp_lat_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_q     = rsp_q_q;
   assign rsp_c     = rsp_c_q;
   assign rsp_lat   = rsp_lat_q;
   assign bus_r     = bus_r_q;
   assign bus_e     = bus_e_q;
   assign bus_w     = bus_w_q;
   assign bus_s     = bus_s_q;
   assign bus_a     = bus_a_q;
   assign bus_d     = bus_d_q;

endmodule

// File: tb/tb_cog_hub_req.sv
// Directed bench for cog_hub_req: inputs change on the falling edge,
// outputs are compared on the falling edge against hand-derived values.
module tb_cog_hub_req;
   import hub_defs::*;

   localparam int LAT_W = 4;

   logic             clk_cog = 1'b0;
   logic             nres;
   logic             ena_bus;
   logic             cog_ena;
   logic             req_valid;
   logic             req_ready;
   logic             req_r;
   logic             req_w;
   logic [1:0]       req_s;
   logic [15:0]      req_a;
   logic [31:0]      req_d;
   logic             rsp_valid;
   logic [31:0]      rsp_q;
   logic             rsp_c;
   logic [LAT_W-1:0] rsp_lat;
   logic             bus_r;
   logic             bus_e;
   logic             bus_w;
   logic [1:0]       bus_s;
   logic [15:0]      bus_a;
   logic [31:0]      bus_d;
   logic [31:0]      bus_q;
   logic             bus_c;
   logic             bus_ack;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_cog = ~clk_cog;

   cog_hub_req #(.LAT_W(LAT_W)) dut (
      .clk_cog   (clk_cog),
      .nres      (nres),
      .ena_bus   (ena_bus),
      .cog_ena   (cog_ena),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_r     (req_r),
      .req_w     (req_w),
      .req_s     (req_s),
      .req_a     (req_a),
      .req_d     (req_d),
      .rsp_valid (rsp_valid),
      .rsp_q     (rsp_q),
      .rsp_c     (rsp_c),
      .rsp_lat   (rsp_lat),
      .bus_r     (bus_r),
      .bus_e     (bus_e),
      .bus_w     (bus_w),
      .bus_s     (bus_s),
      .bus_a     (bus_a),
      .bus_d     (bus_d),
      .bus_q     (bus_q),
      .bus_c     (bus_c),
      .bus_ack   (bus_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_cog);
   endtask

   // Presents one op for a single rising edge, then drops req_valid
   task automatic issue(input logic r, input logic w, input logic [1:0] s,
                        input logic [15:0] a, input logic [31:0] d);
      req_r     = r;
      req_w     = w;
      req_s     = s;
      req_a     = a;
      req_d     = d;
      req_valid = 1'b1;
      step(1);
      req_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nres      = 1'b0;
      ena_bus   = 1'b1;
      cog_ena   = 1'b1;
      req_valid = 1'b0;
      req_r     = 1'b0;
      req_w     = 1'b0;
      req_s     = 2'b00;
      req_a     = 16'h0000;
      req_d     = 32'h0;
      bus_q     = 32'h0;
      bus_c     = 1'b0;
      bus_ack   = 1'b0;
      #2;
      chk("rst_bus_e",     32'(bus_e),     32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_q",     rsp_q,          32'h0);
      chk("rst_rsp_lat",   32'(rsp_lat),   32'd0);
      chk("rst_bus_a",     32'(bus_a),     32'h0);
      chk("rst_bus_d",     bus_d,          32'h0);
      step(2);
      nres = 1'b1;
      step(1);

      // ack seen while idle must not produce a response
      bus_ack = 1'b1;
      step(1);
      chk("idle_ack_rsp",   32'(rsp_valid), 32'd0);
      chk("idle_ack_ready", 32'(req_ready), 32'd1);
      bus_ack = 1'b0;

      // request with the cog stopped is not accepted
      cog_ena = 1'b0;
      issue(1'b1, 1'b0, SZ_LONG, 16'h2222, 32'h0);
      chk("stopped_no_issue", 32'(bus_e), 32'd0);
      cog_ena = 1'b1;

      // 1: rdlong 0x1234, ack on the third edge after issue
      issue(1'b1, 1'b0, SZ_LONG, 16'h1234, 32'h0);
      chk("t1_bus_e",  32'(bus_e),     32'd1);
      chk("t1_bus_a",  32'(bus_a),     32'h1234);
      chk("t1_bus_s",  32'(bus_s),     32'd2);
      chk("t1_bus_r",  32'(bus_r),     32'd1);
      chk("t1_ready",  32'(req_ready), 32'd0);
      step(2);
      bus_q   = 32'h1111_1111;
      bus_ack = 1'b1;
      step(1);
      chk("t1_bus_e_after_ack", 32'(bus_e), 32'd0);
      chk("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
      bus_ack = 1'b0;
      bus_q   = 32'hDEAD_BEEF;
      step(1);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t1_rsp_q",     rsp_q,          32'hDEAD_BEEF);
      chk("t1_rsp_lat",   32'(rsp_lat),   32'd3);
      chk("t1_ready",     32'(req_ready), 32'd1);
      step(1);
      chk("t1_rsp_once",  32'(rsp_valid), 32'd0);

      // 2: wrbyte 0x0005 <- 0xAB, request fields must hold through WAIT
      issue(1'b0, 1'b1, SZ_BYTE, 16'h0005, 32'h0000_00AB);
      chk("t2_bus_s", 32'(bus_s), 32'd0);
      chk("t2_bus_w", 32'(bus_w), 32'd1);
      chk("t2_bus_a", 32'(bus_a), 32'h0005);
      chk("t2_bus_d", bus_d,      32'h0000_00AB);
      req_a = 16'h9999;
      req_d = 32'hFFFF_FFFF;
      req_s = SZ_LONG;
      step(2);
      chk("t2_hold_a", 32'(bus_a), 32'h0005);
      chk("t2_hold_d", bus_d,      32'h0000_00AB);
      chk("t2_hold_s", 32'(bus_s), 32'd0);
      bus_ack = 1'b1;
      step(1);
      chk("t2_bus_e_low", 32'(bus_e),     32'd0);
      chk("t2_no_rsp",    32'(rsp_valid), 32'd0);
      bus_ack = 1'b0;
      bus_c   = 1'b0;
      step(1);
      chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t2_rsp_c",     32'(rsp_c),     32'd0);
      chk("t2_rsp_lat",   32'(rsp_lat),   32'd3);

      // 3: coginit sys op, carry returned set
      issue(1'b0, 1'b0, SZ_SYS, {13'd0, SYS_COGINIT}, 32'h0000_0008);
      chk("t3_bus_s", 32'(bus_s), 32'd3);
      chk("t3_bus_a", 32'(bus_a), 32'h0002);
      chk("t3_bus_d", bus_d,      32'h0000_0008);
      bus_ack = 1'b1;
      step(1);
      bus_ack = 1'b0;
      bus_q   = 32'h8000_0005;
      bus_c   = 1'b1;
      step(1);
      chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t3_rsp_c",     32'(rsp_c),     32'd1);
      chk("t3_rsp_q",     rsp_q,          32'h8000_0005);
      chk("t3_rsp_lat",   32'(rsp_lat),   32'd1);
      bus_c = 1'b0;

      // 4: ack withheld 20 edges, counter saturates
      issue(1'b1, 1'b0, SZ_LONG, 16'h4000, 32'h1357_9BDF);
      step(20);
      chk("t4_bus_e",  32'(bus_e),     32'd1);
      chk("t4_bus_a",  32'(bus_a),     32'h4000);
      chk("t4_bus_d",  bus_d,          32'h1357_9BDF);
      chk("t4_ready",  32'(req_ready), 32'd0);
      bus_ack = 1'b1;
      step(1);
      bus_ack = 1'b0;
      bus_q   = 32'h0BAD_F00D;
      step(1);
      chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t4_rsp_lat",   32'(rsp_lat),   32'd15);
      chk("t4_rsp_q",     rsp_q,          32'h0BAD_F00D);

      // 5: cog stopped during WAIT aborts without a response
      issue(1'b1, 1'b0, SZ_WORD, 16'h0100, 32'h0);
      step(1);
      cog_ena = 1'b0;
      bus_ack = 1'b1;
      step(1);
      chk("t5_bus_e",  32'(bus_e),     32'd0);
      chk("t5_ready",  32'(req_ready), 32'd1);
      chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
      cog_ena = 1'b1;
      step(1);
      chk("t5_no_rsp_later", 32'(rsp_valid), 32'd0);
      chk("t5_idle_bus_e",   32'(bus_e),     32'd0);
      bus_ack = 1'b0;

      // 6: async reset mid-op, then a fresh op completes
      issue(1'b1, 1'b0, SZ_LONG, 16'h0200, 32'h0);
      step(1);
      #1;
      nres = 1'b0;
      #1;
      chk("t6_async_bus_e", 32'(bus_e),     32'd0);
      chk("t6_async_ready", 32'(req_ready), 32'd1);
      chk("t6_rsp_q_clr",   rsp_q,          32'h0);
      chk("t6_rsp_lat_clr", 32'(rsp_lat),   32'd0);
      step(1);
      nres = 1'b1;
      step(1);
      chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
      issue(1'b1, 1'b0, SZ_WORD, 16'h0010, 32'h0);
      chk("t6_bus_e", 32'(bus_e), 32'd1);
      bus_ack = 1'b1;
      step(1);
      bus_ack = 1'b0;
      bus_q   = 32'h0000_CAFE;
      step(1);
      chk("t6_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t6_rsp_q",     rsp_q,          32'h0000_CAFE);
      chk("t6_rsp_lat",   32'(rsp_lat),   32'd1);

      // 7: ena_bus low freezes state and counter, even with ack present
      issue(1'b1, 1'b0, SZ_LONG, 16'h0300, 32'h0);
      step(1);
      ena_bus = 1'b0;
      bus_ack = 1'b1;
      step(5);
      chk("t7_frozen_bus_e", 32'(bus_e),     32'd1);
      chk("t7_frozen_ready", 32'(req_ready), 32'd0);
      bus_ack = 1'b0;
      ena_bus = 1'b1;
      step(1);
      bus_ack = 1'b1;
      step(1);
      chk("t7_bus_e_low", 32'(bus_e), 32'd0);
      bus_ack = 1'b0;
      bus_q   = 32'h7777_0000;
      step(1);
      chk("t7_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t7_rsp_lat",   32'(rsp_lat),   32'd3);
      chk("t7_rsp_q",     rsp_q,          32'h7777_0000);
      step(1);
      chk("t7_rsp_once",  32'(rsp_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
